pcie_msi_intc: RTL and testbench
================================

# pcie_msi_intc

Multi-source PCIe interrupt controller placed between user interrupt sources and the PCIe core's CFG interrupt port. It latches edge-triggered sources into pending/status bits and applies a per-source mask. With MSI enabled it issues one MSI per arm event, mapping each source to a vector within the granted multiple-message range. Otherwise it drives legacy INTx assert/deassert messages that follow the aggregate eligible level.

## Interface
- N_SRC, 8, number of interrupt sources (1..32)
- RR_EN_DEF, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- Reset PCIE_RST is asynchronous and active-high; clock is PCIE_CLK.
- PCIE_CLK  in  1  clock
- PCIE_RST  in  1  async reset, active-high
- CFG_INTERRUPT_N  out  1  interrupt request to core, active-low
- CFG_INTERRUPT_RDY_N  in  1  core grant, active-low
- CFG_INTERRUPT_DI  out  8  MSI vector number; 0 for legacy
- CFG_INTERRUPT_ASSERT_N  out  1  legacy: 0 = assert, 1 = deassert
- CFG_INTERRUPT_MSIENABLE  in  1  MSI enabled by host
- CFG_INTERRUPT_MMENABLE  in  3  granted vectors = 2^MMENABLE (values above 5 treated as 5)
- INTR_FACT  in  N_SRC  source levels; a rising edge arms the source
- INTR_MASK  in  N_SRC  1 = source masked
- INTR_CLR  in  N_SRC  per-bit clear pulse (write-1-to-clear)
- INTR_STATUS  out  N_SRC  pending bits (unmasked view)
- INTR_PEND  out  1  OR of (status & ~mask)

## Operation
- Edge detect: fact_d <= INTR_FACT. A rising edge sets status[i] and clears sent[i]. On the same cycle, set beats INTR_CLR.
- INTR_CLR[i] clears status[i] and sent[i].
- A source is eligible when status & ~mask & ~sent.
- The arbiter selects among eligible sources; round-robin pointer advances past a source only after its grant completes.
- Vector mapping: DI = min(src, 2^MMENABLE - 1). The value is registered at request start and held stable until grant.
- FSM states: IDLE, MSI_REQ, LEG_ASSERT, LEG_ACTIVE, LEG_DEASSERT.
- IDLE:
  - Requests start only when RDY_N = 1.
  - MSIENABLE = 1 and any source eligible -> MSI_REQ.
  - MSIENABLE = 0 and INTR_PEND = 1 -> LEG_ASSERT.
- MSI_REQ: CFG_INTERRUPT_N = 0. On RDY_N = 0, set sent[src], release the request, and return to IDLE.
- LEG_ASSERT: CFG_INTERRUPT_N = 0, ASSERT_N = 0. On RDY_N = 0 -> LEG_ACTIVE.
- LEG_ACTIVE:
  - When INTR_PEND = 0 -> LEG_DEASSERT.
  - When MSIENABLE rises -> LEG_DEASSERT. Deassert always completes before MSI use.
- LEG_DEASSERT: CFG_INTERRUPT_N = 0, ASSERT_N = 1. On RDY_N = 0 -> IDLE.
- Masking a source mid-request does not abort the request; the message completes.
- A new edge on a pending, already-sent source re-arms it and produces a second MSI.

## Timing
- Reset values:
  - CFG_INTERRUPT_N = 1, ASSERT_N = 1, DI = 0
  - INTR_STATUS = 0, INTR_PEND = 0
  - FSM = IDLE; round-robin pointer = 0
- Latency: INTR_FACT first sampled high at edge t -> status set at edge t -> CFG_INTERRUPT_N low after edge t+1, if IDLE and RDY_N = 1.
- All outputs are registered. CFG_INTERRUPT_N, DI and ASSERT_N stay stable from request until the cycle after RDY_N is sampled low.
- Back-to-back MSIs: at least one IDLE cycle between requests.
- Reset mid-request: all outputs return immediately to reset values; no message is resumed.

## Configuration
- PCIE_INT_LEGACY_EN defined: the LEG_* states and INTx behaviour are as described above.
- PCIE_INT_LEGACY_EN undefined:
  - LEG_* states are removed and ASSERT_N is tied to 1.
  - With MSIENABLE = 0, sources still latch into INTR_STATUS but no request is issued.
  - Pending sources are sent once MSIENABLE rises.

## Structure
- Package pcie_int_pkg holds:
  - FSM state encoding (one-hot, 5 bits)
  - max source count (32), MMENABLE clamp value (5)
  - vector width (8)
- Sub-module pcie_int_rr_arb: N_SRC-wide request vector in, one-hot grant plus binary index out, with pointer update on an advance strobe. It also supports fixed-priority mode.

## Test plan
- MSI, MMENABLE = 3, N_SRC = 8: edge on source 5, RDY_N low 3 cycles after request -> one request with DI = 5; STATUS = 0x20; sent set, no repeat.
- Vector clamp: MMENABLE = 1, edges on sources 0 and 6 together -> two MSIs with DI = 0 then DI = 1; round-robin order is 0 then 6.
- Mask: INTR_MASK = 0x04, edge on source 2 -> STATUS = 0x04, PEND = 0, no request. Unmask -> MSI with DI = 2 within 2 cycles.
- Simultaneous set/clear: edge on source 1 and INTR_CLR = 0x02 in the same cycle -> STATUS[1] = 1 and an MSI is issued.
- Legacy (macro defined): MSIENABLE = 0, edge on source 3 -> assert message with ASSERT_N = 0. INTR_CLR = 0x08 -> deassert message with ASSERT_N = 1, then IDLE.
- Reset mid-MSI_REQ: PCIE_RST pulse while CFG_INTERRUPT_N = 0 -> CFG_INTERRUPT_N = 1 and STATUS = 0 immediately; no request after release.

Source files
------------

// File: rtl/pcie_int_pkg.sv
// Shared types and constants for the PCIe MSI/INTx interrupt controller.
package pcie_int_pkg;

    localparam int unsigned MAX_SRC = 32;
    localparam int unsigned MM_MAX  = 5;
    localparam int unsigned VEC_W   = 8;
    localparam int unsigned IDX_W   = 5;

    typedef enum logic [4:0] {
        ST_IDLE         = 5'b00001,
        ST_MSI_REQ      = 5'b00010,
        ST_LEG_ASSERT   = 5'b00100,
        ST_LEG_ACTIVE   = 5'b01000,
        ST_LEG_DEASSERT = 5'b10000
    } int_state_e;

    // Registered CFG interrupt message presented to the core
    typedef struct packed {
        logic             int_n;
        logic             assert_n;
        logic [VEC_W-1:0] di;
    } cfg_msg_t;

    localparam cfg_msg_t MSG_IDLE = '{int_n: 1'b1, assert_n: 1'b1, di: '0};

    // Source index folded into the granted multiple-message range
    function automatic logic [VEC_W-1:0] msi_vector(input logic [IDX_W-1:0] src,
                                                    input logic [2:0]       mm);
        logic [2:0]       mm_c;
        logic [VEC_W-1:0] top;
        mm_c = (mm > 3'(MM_MAX)) ? 3'(MM_MAX) : mm;
        top  = VEC_W'((9'd1 << mm_c) - 9'd1);
        return (VEC_W'(src) < top) ? VEC_W'(src) : top;
    endfunction

endpackage

// File: rtl/pcie_int_rr_arb.sv
// Round-robin / fixed-priority arbiter; pointer moves past a source only when told its grant finished.
module pcie_int_rr_arb
    import pcie_int_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter bit          RR_EN = 1'b1
) (
    input  logic             PCIE_CLK,
    input  logic             PCIE_RST,
    input  logic [N_SRC-1:0] req,
    input  logic             advance,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [N_SRC-1:0] grant_c,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             grant_vld_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] base;

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            ptr_q <= '0;
        end else if (advance && RR_EN) begin
            ptr_q <= ((32'(adv_idx) + 32'd1) >= N_SRC) ? '0 : adv_idx + IDX_W'(1);
        end
    end

    assign base = RR_EN ? ptr_q : '0;

    // First pass searches upward from the pointer, second pass wraps to the bottom
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_vld_c = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!grant_vld_c && req[i] && (IDX_W'(i) >= base)) begin
                grant_vld_c = 1'b1;
                grant_idx_c = IDX_W'(i);
                grant_c[i]  = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!grant_vld_c && req[i]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = IDX_W'(i);
                grant_c[i]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_msi_intc.sv
// Multi-source PCIe interrupt controller: edge-latched sources to MSI messages, or to
// INTx assert/deassert messages when PCIE_INT_LEGACY_EN is defined.
module pcie_msi_intc
    import pcie_int_pkg::*;
#(
    parameter int unsigned N_SRC     = 8,
    parameter bit          RR_EN_DEF = 1'b1
) (
    input  logic             PCIE_CLK,
    input  logic             PCIE_RST,
    output logic             CFG_INTERRUPT_N,
    input  logic             CFG_INTERRUPT_RDY_N,
    output logic [VEC_W-1:0] CFG_INTERRUPT_DI,
    output logic             CFG_INTERRUPT_ASSERT_N,
    input  logic             CFG_INTERRUPT_MSIENABLE,
    input  logic [2:0]       CFG_INTERRUPT_MMENABLE,
    input  logic [N_SRC-1:0] INTR_FACT,
    input  logic [N_SRC-1:0] INTR_MASK,
    input  logic [N_SRC-1:0] INTR_CLR,
    output logic [N_SRC-1:0] INTR_STATUS,
    output logic             INTR_PEND
);

    logic [N_SRC-1:0] fact_d, status_q, status_nxt, sent_q, rise, eligible, set_sent;
    logic [N_SRC-1:0] req_oh_q, req_oh_nxt, arb_grant;
    logic [IDX_W-1:0] req_idx_q, req_idx_nxt, arb_idx;
    logic             arb_vld, pend_q, grant_done;
    int_state_e       state_q, state_nxt;
    cfg_msg_t         msg_q, msg_nxt;

    assign rise       = INTR_FACT & ~fact_d;
    assign eligible   = status_q & ~INTR_MASK & ~sent_q;
    assign status_nxt = (status_q & ~INTR_CLR) | rise;
    assign set_sent   = grant_done ? req_oh_q : '0;

    pcie_int_rr_arb #(.N_SRC(N_SRC), .RR_EN(RR_EN_DEF)) u_arb (
        .PCIE_CLK    (PCIE_CLK),
        .PCIE_RST    (PCIE_RST),
        .req         (eligible),
        .advance     (grant_done),
        .adv_idx     (req_idx_q),
        .grant_c     (arb_grant),
        .grant_idx_c (arb_idx),
        .grant_vld_c (arb_vld)
    );

    // A fresh edge re-arms the source even if it was sent in the same cycle
    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            fact_d   <= '0;
            status_q <= '0;
            sent_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            fact_d   <= INTR_FACT;
            status_q <= status_nxt;
            sent_q   <= (sent_q | set_sent) & ~INTR_CLR & ~rise;
            pend_q   <= |(status_nxt & ~INTR_MASK);
        end
    end

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            state_q   <= ST_IDLE;
            msg_q     <= MSG_IDLE;
            req_idx_q <= '0;
            req_oh_q  <= '0;
        end else begin
            state_q   <= state_nxt;
            msg_q     <= msg_nxt;
            req_idx_q <= req_idx_nxt;
            req_oh_q  <= req_oh_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        msg_nxt     = msg_q;
        req_idx_nxt = req_idx_q;
        req_oh_nxt  = req_oh_q;
        grant_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CFG_INTERRUPT_RDY_N) begin
                    if (CFG_INTERRUPT_MSIENABLE && arb_vld) begin
                        state_nxt   = ST_MSI_REQ;
                        req_idx_nxt = arb_idx;
                        req_oh_nxt  = arb_grant;
                        msg_nxt     = '{int_n: 1'b0, assert_n: 1'b1,
                                        di: msi_vector(arb_idx, CFG_INTERRUPT_MMENABLE)};
                    end
`ifdef PCIE_INT_LEGACY_EN
                    else if (!CFG_INTERRUPT_MSIENABLE && pend_q) begin
                        state_nxt = ST_LEG_ASSERT;
                        msg_nxt   = '{int_n: 1'b0, assert_n: 1'b0, di: '0};
                    end
`endif
                end
            end
            ST_MSI_REQ: begin
                if (!CFG_INTERRUPT_RDY_N) begin
                    grant_done = 1'b1;
                    state_nxt  = ST_IDLE;
                    msg_nxt    = MSG_IDLE;
                end
            end
`ifdef PCIE_INT_LEGACY_EN
            ST_LEG_ASSERT: begin
                if (!CFG_INTERRUPT_RDY_N) begin
                    state_nxt = ST_LEG_ACTIVE;
                    msg_nxt   = MSG_IDLE;
                end
            end
            // INTx must be withdrawn before the host can be served by MSI
            ST_LEG_ACTIVE: begin
                if (!pend_q || CFG_INTERRUPT_MSIENABLE) begin
                    state_nxt = ST_LEG_DEASSERT;
                    msg_nxt   = '{int_n: 1'b0, assert_n: 1'b1, di: '0};
                end
            end
            ST_LEG_DEASSERT: begin
                if (!CFG_INTERRUPT_RDY_N) begin
                    state_nxt = ST_IDLE;
                    msg_nxt   = MSG_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                msg_nxt   = MSG_IDLE;
            end
        endcase
    end

    assign CFG_INTERRUPT_N        = msg_q.int_n;
    assign CFG_INTERRUPT_ASSERT_N = msg_q.assert_n;
    assign CFG_INTERRUPT_DI       = msg_q.di;
    assign INTR_STATUS            = status_q;
    assign INTR_PEND              = pend_q;

endmodule

// File: tb/tb_pcie_msi_intc.sv
// Scoreboard bench for pcie_msi_intc: a reference model queues expected messages, a monitor checks
// each request the DUT raises; a core responder grants after a delay. Honors PCIE_INT_LEGACY_EN.
module tb_pcie_msi_intc;

    localparam int N = 8;

    logic         clk, rst;
    logic         int_n, rdy_n, assert_n, msien, pend;
    logic [7:0]   di;
    logic [2:0]   mm;
    logic [N-1:0] fact, mask, clr, status;

    int vectors, miscompares, req_count, rr_ptr, rdy_delay;
    bit hold_rdy;
    logic [8:0] exp_q[$];

    pcie_msi_intc #(.N_SRC(N), .RR_EN_DEF(1'b1)) dut (
        .PCIE_CLK                (clk),
        .PCIE_RST                (rst),
        .CFG_INTERRUPT_N         (int_n),
        .CFG_INTERRUPT_RDY_N     (rdy_n),
        .CFG_INTERRUPT_DI        (di),
        .CFG_INTERRUPT_ASSERT_N  (assert_n),
        .CFG_INTERRUPT_MSIENABLE (msien),
        .CFG_INTERRUPT_MMENABLE  (mm),
        .INTR_FACT               (fact),
        .INTR_MASK               (mask),
        .INTR_CLR                (clr),
        .INTR_STATUS             (status),
        .INTR_PEND               (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected MSIs for sources armed together: circular order from the pointer, vector clamped
    function automatic void model_batch(input logic [N-1:0] elig, input logic [2:0] mmv);
        int top;
        int last;
        top  = (1 << ((mmv > 3'd5) ? 5 : int'(mmv))) - 1;
        last = -1;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (rr_ptr + k) % N;
            if (elig[s]) begin
                exp_q.push_back({1'b1, 8'((s < top) ? s : top)});
                last = s;
            end
        end
        if (last >= 0) rr_ptr = (last + 1) % N;
    endfunction

    // Monitor: every new request is compared against the scoreboard head
    initial begin
        logic       prev_n;
        logic [8:0] cur;
        prev_n = 1'b1;
        cur    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_n = 1'b1;
            end else begin
                if (!int_n && prev_n) begin
                    req_count++;
                    cur = {assert_n, di};
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_request: got 0x%0h, expected none", cur);
                    end else begin
                        check("message", 32'(cur), 32'(exp_q.pop_front()));
                    end
                end else if (!int_n) begin
                    check("message_stable", 32'({assert_n, di}), 32'(cur));
                end
                prev_n = int_n;
            end
        end
    end

    // Core model: grant each request after a fixed or random delay
    initial begin
        int d;
        rdy_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!int_n && !hold_rdy && !rst) begin
                d = (rdy_delay < 0) ? int'($urandom_range(0, 3)) : rdy_delay;
                repeat (d) @(negedge clk);
                rdy_n = 1'b0;
                @(negedge clk);
                rdy_n = 1'b1;
            end
        end
    end

    task automatic pulse_edge(input logic [N-1:0] s);
        @(negedge clk);
        fact = s;
        @(negedge clk);
        fact = '0;
    endtask

    task automatic pulse_clr(input logic [N-1:0] c);
        @(negedge clk);
        clr = c;
        @(negedge clk);
        clr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic drain(input string name);
        int quiet;
        int t;
        quiet = 0;
        t     = 0;
        while ((exp_q.size() != 0 || quiet < 4) && t < 400) begin
            @(negedge clk);
            t++;
            if (exp_q.size() == 0 && int_n) quiet++;
            else quiet = 0;
        end
        if (t >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d messages outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cnt;
        logic [N-1:0]  s, m;
        logic [2:0]    mmv;
        vectors = 0; miscompares = 0; req_count = 0; rr_ptr = 0; rdy_delay = -1;
        hold_rdy = 1'b0;
        rst = 1'b1; msien = 1'b1; mm = 3'd3;
        fact = '0; mask = '0; clr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_int_n", 32'(int_n), 32'd1);
        check("reset_assert_n", 32'(assert_n), 32'd1);
        check("reset_di", 32'(di), 32'd0);
        check("reset_status", 32'(status), 32'd0);
        check("reset_pend", 32'(pend), 32'd0);

        // Single source, slow grant, no repeat
        rdy_delay = 3;
        cnt = req_count;
        model_batch(8'h20, mm);
        pulse_edge(8'h20);
        drain("single");
        repeat (8) @(negedge clk);
        check("single_status", 32'(status), 32'h20);
        check("single_pend", 32'(pend), 32'd1);
        check("single_count", 32'(req_count - cnt), 32'd1);
        pulse_clr('1);
        rdy_delay = -1;

        // Vector clamp with round-robin from pointer 0
        do_reset();
        mm = 3'd1;
        model_batch(8'h41, mm);
        pulse_edge(8'h41);
        drain("clamp");
        pulse_clr('1);

        // Masked source latches but waits for unmask
        mm = 3'd3;
        mask = 8'h04;
        cnt = req_count;
        pulse_edge(8'h04);
        repeat (5) @(negedge clk);
        check("mask_status", 32'(status), 32'h04);
        check("mask_pend", 32'(pend), 32'd0);
        check("mask_no_req", 32'(req_count - cnt), 32'd0);
        model_batch(8'h04, mm);
        mask = '0;
        @(negedge clk);
        if (int_n) @(negedge clk);
        check("unmask_latency", 32'(int_n), 32'd0);
        drain("unmask");
        pulse_clr('1);

        // Set beats clear in the same cycle
        model_batch(8'h02, mm);
        @(negedge clk);
        fact = 8'h02;
        clr  = 8'h02;
        @(negedge clk);
        fact = '0;
        clr  = '0;
        check("setclr_status", 32'(status & 8'h02), 32'h02);
        drain("setclr");
        pulse_clr('1);

        // Random batches with random masks and MM ranges
        for (int it = 0; it < 25; it++) begin
            mmv = 3'($urandom_range(0, 7));
            s   = N'($urandom_range(1, 255));
            m   = N'($urandom) & N'($urandom);
            @(negedge clk);
            mm   = mmv;
            mask = m;
            model_batch(s & ~m, mmv);
            pulse_edge(s);
            drain("random");
            check("random_status", 32'(status), 32'(s));
            check("random_pend", 32'(pend), 32'(|(s & ~m)));
            pulse_clr('1);
            mask = '0;
        end

`ifdef PCIE_INT_LEGACY_EN
        // INTx assert, then deassert when the source is cleared
        msien = 1'b0;
        exp_q.push_back({1'b0, 8'h00});
        pulse_edge(8'h08);
        drain("leg_assert");
        check("leg_status", 32'(status), 32'h08);
        exp_q.push_back({1'b1, 8'h00});
        pulse_clr(8'h08);
        drain("leg_deassert");
        check("leg_status_clr", 32'(status), 32'd0);
        check("leg_pend_clr", 32'(pend), 32'd0);
        // MSI enable while INTx active: deassert first, then the MSI
        exp_q.push_back({1'b0, 8'h00});
        pulse_edge(8'h08);
        drain("leg_assert2");
        exp_q.push_back({1'b1, 8'h00});
        model_batch(8'h08, mm);
        msien = 1'b1;
        drain("leg_to_msi");
        pulse_clr('1);
`else
        // Without INTx support, MSI-disabled sources wait for MSI enable
        msien = 1'b0;
        cnt = req_count;
        pulse_edge(8'h08);
        repeat (10) @(negedge clk);
        check("nolegacy_status", 32'(status), 32'h08);
        check("nolegacy_no_req", 32'(req_count - cnt), 32'd0);
        check("nolegacy_assert_n", 32'(assert_n), 32'd1);
        model_batch(8'h08, mm);
        msien = 1'b1;
        drain("nolegacy_msi");
        pulse_clr('1);
`endif

        // Reset in the middle of an ungranted MSI request
        hold_rdy = 1'b1;
        mm = 3'd3;
        model_batch(8'h10, mm);
        pulse_edge(8'h10);
        for (int w = 0; w < 5 && int_n; w++) @(negedge clk);
        check("rst_req_started", 32'(int_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_int_n", 32'(int_n), 32'd1);
        check("rst_status", 32'(status), 32'd0);
        check("rst_di", 32'(di), 32'd0);
        check("rst_assert_n", 32'(assert_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        hold_rdy = 1'b0;
        rr_ptr = 0;
        exp_q.delete();
        cnt = req_count;
        repeat (15) @(negedge clk);
        check("rst_no_resume", 32'(req_count - cnt), 32'd0);
        check("rst_idle_int_n", 32'(int_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
